// File: rtl/sound_level_encoder_pkg.sv
// Shared definitions for the sound level encoder and neighbouring audio /
// display blocks.
//   - Level code width and the NO_SOUND / LEVEL_1..LEVEL_5 codes, which the
//     square coordinate logic also consumes.
//   - Sample and magnitude widths.
//   - next_level(): the attack/decay rule applied at every window close.
package sound_level_encoder_pkg;

  localparam int SOUND_LEVEL_ENCODE_LENGTH = 3;
  localparam int SAMPLE_W                  = 12;
  localparam int MAG_W                     = 11;

  localparam logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] NO_SOUND = 3'd0;
  localparam logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] LEVEL_1  = 3'd1;
  localparam logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] LEVEL_2  = 3'd2;
  localparam logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] LEVEL_3  = 3'd3;
  localparam logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] LEVEL_4  = 3'd4;
  localparam logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] LEVEL_5  = 3'd5;

  // Instant attack, one-level-per-window decay. When raw < cur, cur is at
  // least 1, so the decrement cannot underflow.
  function automatic logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] next_level(
    input logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] raw,
    input logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] cur
  );
    return (raw >= cur) ? raw : cur - 3'd1;
  endfunction

endpackage

// File: rtl/sound_level_encoder_sample_magnitude.sv
// Combinational conversion of an offset-binary microphone ADC code into an
// unsigned distance from silence.
//   sample    : 12-bit ADC code, silence = 2048
//   magnitude : |sample - 2048|, saturated to 2047 so it fits 11 bits
//               (only sample = 0 would otherwise give 2048)
module sound_level_encoder_sample_magnitude
  import sound_level_encoder_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  output logic [MAG_W-1:0]    magnitude
);

  localparam logic [SAMPLE_W-1:0] MIDPOINT = 12'd2048;

  logic [SAMPLE_W-1:0] above;
  logic [SAMPLE_W-1:0] below;

  always_comb begin
    above = sample - MIDPOINT;
    below = MIDPOINT - sample;
    if (sample >= MIDPOINT) begin
      magnitude = above[MAG_W-1:0];
    end else if (sample == '0) begin
      magnitude = 11'd2047;
    end else begin
      magnitude = below[MAG_W-1:0];
    end
  end

endmodule

// File: rtl/sound_level_encoder.sv
// Windowed peak detector that turns a microphone sample stream into a
// 0..5 loudness level.
//   CLK          : system clock
//   RESET        : asynchronous, active-high reset
//   ENABLE       : level-sensitive run enable; low returns to IDLE and clears
//   SAMPLE       : 12-bit offset-binary ADC code (silence = 2048)
//   SAMPLE_VALID : one-cycle strobe qualifying SAMPLE
//   SOUND_LEVEL  : registered level code (NO_SOUND, LEVEL_1..LEVEL_5)
//   LEVEL_VALID  : one-cycle pulse on every SOUND_LEVEL update
//   fsm_state    : current FSM state (0 IDLE, 1 ACCUM, 2 UPDATE) for observation
//
// Stream semantics: there is no ready. Every cycle with SAMPLE_VALID high
// while the FSM is in ACCUM or UPDATE (and ENABLE stays high) is consumed on
// that edge; strobes in IDLE are ignored. LEVEL_VALID is a pure output pulse
// with no back-pressure.
module sound_level_encoder
  import sound_level_encoder_pkg::*;
#(
  parameter int             WINDOW_SAMPLES = 1024,
  parameter logic [MAG_W-1:0] TH_1 = 11'd64,
  parameter logic [MAG_W-1:0] TH_2 = 11'd192,
  parameter logic [MAG_W-1:0] TH_3 = 11'd384,
  parameter logic [MAG_W-1:0] TH_4 = 11'd640,
  parameter logic [MAG_W-1:0] TH_5 = 11'd1024
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic                                 ENABLE,
  input  logic [SAMPLE_W-1:0]                  SAMPLE,
  input  logic                                 SAMPLE_VALID,
  output logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] SOUND_LEVEL,
  output logic                                 LEVEL_VALID,
  output logic [1:0]                           fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } enc_state_t;

  localparam logic [15:0] LAST_INDEX = 16'(WINDOW_SAMPLES - 1);

  enc_state_t                         state_q, state_d;
  logic [15:0]                        count_q, count_d;
  logic [MAG_W-1:0]                   peak_q, peak_d;
  logic [MAG_W-1:0]                   final_q, final_d;
  logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] level_q, level_d;
  logic                               valid_q, valid_d;

  logic [MAG_W-1:0]                   magnitude;
  logic [MAG_W-1:0]                   peak_max;
  logic [SOUND_LEVEL_ENCODE_LENGTH-1:0] raw_level;

  sound_level_encoder_sample_magnitude u_magnitude (
    .sample    (SAMPLE),
    .magnitude (magnitude)
  );

  // Number of thresholds the closed window's peak reached.
  always_comb begin
    raw_level = {2'b00, final_q >= TH_1}
              + {2'b00, final_q >= TH_2}
              + {2'b00, final_q >= TH_3}
              + {2'b00, final_q >= TH_4}
              + {2'b00, final_q >= TH_5};
  end

  assign peak_max = (magnitude > peak_q) ? magnitude : peak_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    peak_d  = peak_q;
    final_d = final_q;
    level_d = level_q;
    valid_d = 1'b0;

    if (!ENABLE) begin
      // Dropping ENABLE discards any window in progress, including a pending
      // update, and parks everything at its idle value.
      state_d = ST_IDLE;
      count_d = '0;
      peak_d  = '0;
      final_d = '0;
      level_d = NO_SOUND;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (SAMPLE_VALID) begin
            if (count_q == LAST_INDEX) begin
              // Closing sample belongs to the window it closes.
              final_d = peak_max;
              peak_d  = '0;
              count_d = '0;
              state_d = ST_UPDATE;
            end else begin
              peak_d  = peak_max;
              count_d = count_q + 16'd1;
            end
          end
        end
        ST_UPDATE: begin
          level_d = next_level(raw_level, level_q);
          valid_d = 1'b1;
          state_d = ST_ACCUM;
          // The new window is already open here; with at least 2 samples per
          // window this strobe can never close it.
          if (SAMPLE_VALID) begin
            peak_d  = peak_max;
            count_d = count_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          peak_d  = '0;
          final_d = '0;
          level_d = NO_SOUND;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      peak_q  <= '0;
      final_q <= '0;
      level_q <= NO_SOUND;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      peak_q  <= peak_d;
      final_q <= final_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  end

  assign SOUND_LEVEL = level_q;
  assign LEVEL_VALID = valid_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_sound_level_encoder.sv
// Self-checking bench for sound_level_encoder with a 4-sample window.
// A window-level model (queue of accepted magnitudes, max over the window,
// threshold count) predicts SOUND_LEVEL / LEVEL_VALID every cycle; directed
// sequences add literal expectations for silence, attack, decay, threshold
// boundaries, back-to-back strobes and aborts.
module tb_sound_level_encoder;

  localparam int W = 4;

  logic        CLK;
  logic        RESET;
  logic        ENABLE;
  logic [11:0] SAMPLE;
  logic        SAMPLE_VALID;
  logic [2:0]  SOUND_LEVEL;
  logic        LEVEL_VALID;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int pulse_cycles[$];

  sound_level_encoder #(.WINDOW_SAMPLES(W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .SAMPLE       (SAMPLE),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SOUND_LEVEL  (SOUND_LEVEL),
    .LEVEL_VALID  (LEVEL_VALID),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  int th[5] = '{64, 192, 384, 640, 1024};

  function automatic int mag_of(input int s);
    if (s >= 2048) return s - 2048;
    return (2048 - s > 2047) ? 2047 : 2048 - s;
  endfunction

  function automatic int level_of(input int pk);
    int n = 0;
    for (int k = 0; k < 5; k++) if (pk >= th[k]) n++;
    return n;
  endfunction

  bit running;
  int win[$];
  bit pending;
  int pend_peak;
  int exp_level;
  bit exp_valid;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      running = 0; win.delete(); pending = 0; pend_peak = 0;
      exp_level = 0; exp_valid = 0;
    end else begin
      exp_valid = 0;
      if (!ENABLE) begin
        running = 0; win.delete(); pending = 0; exp_level = 0;
      end else if (!running) begin
        running = 1;
      end else begin
        if (pending) begin
          int raw;
          raw = level_of(pend_peak);
          exp_level = (raw >= exp_level) ? raw : exp_level - 1;
          exp_valid = 1;
          pending = 0;
        end
        if (SAMPLE_VALID) begin
          win.push_back(mag_of(int'(SAMPLE)));
          if (win.size() == W) begin
            pend_peak = 0;
            foreach (win[i]) if (win[i] > pend_peak) pend_peak = win[i];
            win.delete();
            pending = 1;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    cycle++;
    if (LEVEL_VALID) pulse_cycles.push_back(cycle);
    checks++;
    if (LEVEL_VALID !== exp_valid) begin
      errors++;
      $display("FAIL model_valid cycle %0d: got %0b expected %0b", cycle, LEVEL_VALID, exp_valid);
    end
    checks++;
    if (SOUND_LEVEL !== 3'(exp_level)) begin
      errors++;
      $display("FAIL model_level cycle %0d: got %0d expected %0d", cycle, SOUND_LEVEL, exp_level);
    end
  end

  // ---------------- driver / literal-check tasks ----------------
  task automatic check_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic send(input int s);
    @(negedge CLK);
    SAMPLE = 12'(s);
    SAMPLE_VALID = 1'b1;
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
  endtask

  // Four strobes; pulse must be absent right after the closing edge and
  // present (with the given level) one cycle later.
  task automatic window(input string name, input int s0, input int s1,
                        input int s2, input int s3, input int lvl);
    send(s0); send(s1); send(s2); send(s3);
    check_lit({name, "_early"}, int'(LEVEL_VALID), 0);
    @(negedge CLK);
    check_lit({name, "_valid"}, int'(LEVEL_VALID), 1);
    check_lit({name, "_level"}, int'(SOUND_LEVEL), lvl);
  endtask

  task automatic restart_enable();
    @(negedge CLK); ENABLE = 1'b0;
    @(negedge CLK); ENABLE = 1'b1;
  endtask

  function automatic int pick_sample();
    int tbl[10] = '{0, 2048, 2240, 2239, 1857, 3200, 2111, 2112, 4095, 1024};
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 9)];
    return int'($urandom_range(0, 4095));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    RESET = 1'b1; ENABLE = 1'b0; SAMPLE = 12'd2048; SAMPLE_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    check_lit("reset_level", int'(SOUND_LEVEL), 0);
    check_lit("reset_valid", int'(LEVEL_VALID), 0);
    check_lit("reset_state", int'(fsm_state), 0);
    RESET = 1'b0;
    @(negedge CLK);
    ENABLE = 1'b1;

    window("silence", 2048, 2048, 2048, 2048, 0);
    window("attack_last", 2048, 2048, 2048, 3200, 5);
    window("decay4", 2048, 2048, 2048, 2048, 4);
    window("decay3", 2048, 2048, 2048, 2048, 3);
    window("decay2", 2048, 2048, 2048, 2048, 2);
    window("decay1", 2048, 2048, 2048, 2048, 1);
    window("decay0", 2048, 2048, 2048, 2048, 0);
    window("zero_sample", 2048, 0, 2048, 2048, 5);
    restart_enable();
    check_lit("enable_clear", int'(SOUND_LEVEL), 0);
    window("mag192", 2048, 2240, 2048, 2048, 2);
    restart_enable();
    window("mag191", 1857, 2048, 2048, 2048, 1);

    // Back-to-back strobes across the window close.
    repeat (2) @(negedge CLK);
    pulse_cycles.delete();
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge CLK);
      SAMPLE = 12'(2048 + 100 * i);
      SAMPLE_VALID = 1'b1;
    end
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    check_lit("b2b_pulses", pulse_cycles.size(), 2);
    if (pulse_cycles.size() == 2)
      check_lit("b2b_spacing", pulse_cycles[1] - pulse_cycles[0], W);

    // Reset abort after 2 of 4 samples.
    window("pre_reset", 3200, 2048, 2048, 2048, 5);
    send(3200); send(3200);
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    pulse_cycles.delete();
    repeat (5) @(negedge CLK);
    check_lit("reset_abort_pulses", pulse_cycles.size(), 0);
    check_lit("reset_abort_level", int'(SOUND_LEVEL), 0);
    window("after_reset", 2048, 2048, 2048, 2240, 2);

    // ENABLE abort after 2 of 4 samples.
    send(3200); send(3200);
    @(negedge CLK); ENABLE = 1'b0;
    pulse_cycles.delete();
    repeat (3) @(negedge CLK);
    ENABLE = 1'b1;
    repeat (3) @(negedge CLK);
    check_lit("enable_abort_pulses", pulse_cycles.size(), 0);
    check_lit("enable_abort_level", int'(SOUND_LEVEL), 0);
    window("after_enable", 2048, 2048, 2111, 2048, 0);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RESET = ($urandom_range(0, 299) == 0);
      ENABLE = ($urandom_range(0, 39) != 0);
      SAMPLE_VALID = ($urandom_range(0, 2) != 0);
      SAMPLE = 12'(pick_sample());
    end
    @(negedge CLK);
    RESET = 1'b0; SAMPLE_VALID = 1'b0;
    repeat (4) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_level_encoder.md
SOUND_LEVEL_ENCODER -- requirements
Module: Sound_Level_Encoder

Interface
REQ-001 Parameter WINDOW_SAMPLES, default 1024; valid samples per measurement window (legal range 2..65535).
REQ-002 Parameters TH_1..TH_5, defaults 64, 192, 384, 640, 1024; 11-bit magnitude thresholds; strictly ascending.
REQ-003 CLK  input  1  system clock; the only clock.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 ENABLE  input  1  level-sensitive run enable.
REQ-006 SAMPLE  input  12  microphone ADC code, unsigned offset-binary, silence = 2048.
REQ-007 SAMPLE_VALID  input  1  one-cycle strobe qualifying SAMPLE.
REQ-008 SOUND_LEVEL  output  `SOUND_LEVEL_ENCODE_LENGTH  registered level code: `NO_SOUND, `LEVEL_1..`LEVEL_5.
REQ-009 LEVEL_VALID  output  1  one-cycle pulse on each SOUND_LEVEL update.

Function
REQ-010 Magnitude = |SAMPLE - 2048|; SAMPLE = 0 gives 2048, saturated to 2047 (11 bits).
REQ-011 States: IDLE, ACCUM, UPDATE.
REQ-012 IDLE: count, peak and final_peak held at 0; SOUND_LEVEL = `NO_SOUND; LEVEL_VALID = 0; ENABLE high moves to ACCUM on the next edge.
REQ-013 ACCUM, valid sample: peak <= max(peak, magnitude), count <= count + 1.
REQ-014 Window close is the valid sample that brings count to WINDOW_SAMPLES; that sample is included in the window.
REQ-015 On the window-close edge: final_peak <= max(peak, magnitude); peak <= 0; count <= 0; the FSM enters UPDATE.
REQ-016 UPDATE lasts one cycle and returns to ACCUM.
REQ-017 During UPDATE, a valid sample is accumulated into the new window as in REQ-013; no sample is ever dropped.
REQ-018 raw_level = number of TH_k with final_peak >= TH_k (0..5).
REQ-019 Leaving UPDATE: if raw_level >= current level, SOUND_LEVEL <= raw_level; otherwise SOUND_LEVEL <= current - 1 (instant attack, one-level-per-window decay).
REQ-020 LEVEL_VALID = 1 on the same edge as REQ-019, even when the value is unchanged.
REQ-021 Latency: SOUND_LEVEL and LEVEL_VALID update on the 2nd rising edge after the closing sample is captured.
REQ-022 ENABLE low in any state: IDLE on the next edge, with state cleared per REQ-012; a window in progress is discarded without an update.
REQ-023 SAMPLE_VALID is ignored in IDLE and on the cycle ENABLE rises.
REQ-024 SAMPLE_VALID high on consecutive cycles is legal; every strobe counts.
REQ-025 The counter never exceeds WINDOW_SAMPLES - 1 between edges; no wrap-around.

Reset
REQ-026 RESET high asynchronously forces state = IDLE, count = 0, peak = 0, final_peak = 0, SOUND_LEVEL = `NO_SOUND, LEVEL_VALID = 0.
REQ-027 Reset asserted mid-window or during UPDATE produces no LEVEL_VALID pulse.
REQ-028 After RESET deasserts, the first window starts counting from zero once ENABLE is high.

Structure
REQ-029 `SOUND_LEVEL_ENCODE_LENGTH (3), `NO_SOUND (0) and `LEVEL_1..`LEVEL_5 (1..5) live in Head.v, shared with the square coordinate logic.
REQ-030 The state encodings and the silence midpoint 2048 are local to the module.
REQ-031 One sub-module, Sample_Magnitude: combinational REQ-010 conversion, reusable by other audio blocks.

Verification
REQ-032 WINDOW_SAMPLES = 4; samples 2048 x4 -> one LEVEL_VALID with SOUND_LEVEL = `NO_SOUND, 2 edges after the 4th strobe.
REQ-033 Samples 2048, 2048, 2048, 3200 (magnitude 1152) -> SOUND_LEVEL = `LEVEL_5; the closing sample counts.
REQ-034 Decay: one `LEVEL_5 window followed by silent windows -> levels 4, 3, 2, 1, 0 on successive LEVEL_VALID pulses.
REQ-035 Boundaries: SAMPLE = 0 -> magnitude 2047 -> `LEVEL_5; magnitude exactly 192 -> `LEVEL_2; magnitude 191 -> `LEVEL_1.
REQ-036 Strobe during UPDATE: back-to-back SAMPLE_VALID across the window close -> the next window closes exactly 4 strobes later.
REQ-037 Mid-operation aborts: RESET or ENABLE low after 2 of 4 samples -> no LEVEL_VALID, `NO_SOUND output, and a fresh 4-sample window afterwards.
